// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the iterative multiply/divide engine: operation
// encodings, FSM state encoding, bus widths and small decode helpers.
package mult_div_unit_pkg;

  // Native datapath width and the packed {hi, lo} result width.
  localparam int DATA_BUS     = 32;
  localparam int MULT_DIV_BUS = 2 * DATA_BUS;

  // Operation encodings as presented by EX on the op port.
  localparam logic [1:0] MD_OP_MULT  = 2'b00;
  localparam logic [1:0] MD_OP_MULTU = 2'b01;
  localparam logic [1:0] MD_OP_DIV   = 2'b10;
  localparam logic [1:0] MD_OP_DIVU  = 2'b11;

  // State encoding, kept as plain constants so other blocks can refer to it.
  localparam logic [2:0] MD_ST_IDLE = 3'd0;
  localparam logic [2:0] MD_ST_MUL  = 3'd1;
  localparam logic [2:0] MD_ST_DIV  = 3'd2;
  localparam logic [2:0] MD_ST_FIX  = 3'd3;
  localparam logic [2:0] MD_ST_DONE = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE = MD_ST_IDLE,
    ST_MUL  = MD_ST_MUL,
    ST_DIV  = MD_ST_DIV,
    ST_FIX  = MD_ST_FIX,
    ST_DONE = MD_ST_DONE
  } md_state_e;

  // Divide operations have the upper op bit set.
  function automatic logic op_is_div(input logic [1:0] op);
    return (op == MD_OP_DIV) || (op == MD_OP_DIVU);
  endfunction

  // Signed operations have the lower op bit clear.
  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == MD_OP_MULT) || (op == MD_OP_DIV);
  endfunction

endpackage

// File: rtl/mult_div_unit_div_step.sv
// One iteration of restoring division: shift the next dividend bit into the
// partial remainder and subtract the divisor when it fits.
module div_restoring_step
  import mult_div_unit_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_BUS
) (
  input  logic [DATA_WIDTH-1:0] rem,
  input  logic                  dividend_bit,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic [DATA_WIDTH-1:0] rem_next,
  output logic                  quot_bit
);

  logic [DATA_WIDTH:0] shifted;
  logic [DATA_WIDTH:0] diff;

  // The remainder is always below the divisor, so the shifted value is below
  // twice the divisor and the top bit of the difference is a clean borrow.
  always_comb begin
    shifted  = {rem, dividend_bit};
    diff     = shifted - {1'b0, divisor};
    quot_bit = ~diff[DATA_WIDTH];
    rem_next = quot_bit ? diff[DATA_WIDTH-1:0] : shifted[DATA_WIDTH-1:0];
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide engine for the EX stage HI/LO path. Works on
// operand magnitudes and applies signs in a final FIX cycle.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_BUS,
  parameter int FAST_MUL   = 0,
  parameter int CNT_WIDTH  = $clog2(DATA_WIDTH) + 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      start,
  input  logic [1:0]                op,
  input  logic [DATA_WIDTH-1:0]     operand_1,
  input  logic [DATA_WIDTH-1:0]     operand_2,
  input  logic                      hold,
  output logic                      busy,
  output logic                      done,
  output logic [2*DATA_WIDTH-1:0]   result
);

  localparam int W = DATA_WIDTH;
  localparam logic [CNT_WIDTH-1:0] CNT_LOAD = CNT_WIDTH'(DATA_WIDTH);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(1);

  md_state_e            state;
  logic [CNT_WIDTH-1:0] counter;
  logic                 neg_a;
  logic                 neg_b;
  logic                 is_div;
  logic [W-1:0]         abs_a;
  logic [W-1:0]         abs_b;
  // acc is {hi, lo}: multiply keeps the running sum in hi and the multiplier
  // shifting out of lo; divide keeps the remainder in hi and the dividend
  // shifting out of lo while quotient bits shift in.
  logic [2*W-1:0]       acc;

  logic                 sign_1;
  logic                 sign_2;
  logic [W-1:0]         in_abs_1;
  logic [W-1:0]         in_abs_2;
  logic [W:0]           mul_sum;
  logic [2*W-1:0]       mul_next;
  logic [2*W-1:0]       fast_prod;
  logic [W-1:0]         div_rem_next;
  logic                 div_quot_bit;
  logic [2*W-1:0]       div_next;
  logic [2*W-1:0]       fix_prod;
  logic [W-1:0]         fix_quot;
  logic [W-1:0]         fix_rem;

  div_restoring_step #(
    .DATA_WIDTH(W)
  ) u_div_step (
    .rem          (acc[2*W-1:W]),
    .dividend_bit (acc[W-1]),
    .divisor      (abs_b),
    .rem_next     (div_rem_next),
    .quot_bit     (div_quot_bit)
  );

  // Operand magnitudes, per-cycle datapath updates and sign correction.
  always_comb begin
    sign_1    = op_is_signed(op) & operand_1[W-1];
    sign_2    = op_is_signed(op) & operand_2[W-1];
    in_abs_1  = sign_1 ? -operand_1 : operand_1;
    in_abs_2  = sign_2 ? -operand_2 : operand_2;
    mul_sum   = {1'b0, acc[2*W-1:W]} + ({1'b0, abs_a} & {(W+1){acc[0]}});
    mul_next  = {mul_sum, acc[W-1:1]};
    fast_prod = {{W{1'b0}}, abs_a} * {{W{1'b0}}, abs_b};
    div_next  = {div_rem_next, acc[W-2:0], div_quot_bit};
    fix_prod  = (neg_a ^ neg_b) ? -acc : acc;
    fix_quot  = (neg_a ^ neg_b) ? -acc[W-1:0] : acc[W-1:0];
    fix_rem   = neg_a ? -acc[2*W-1:W] : acc[2*W-1:W];
  end

  // Control FSM and datapath registers; reset beats flush beats normal flow.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
      counter <= '0;
      neg_a   <= 1'b0;
      neg_b   <= 1'b0;
      is_div  <= 1'b0;
      abs_a   <= '0;
      abs_b   <= '0;
      acc     <= '0;
    end else if (flush) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            neg_a   <= sign_1;
            neg_b   <= sign_2;
            abs_a   <= in_abs_1;
            abs_b   <= in_abs_2;
            is_div  <= op_is_div(op);
            counter <= CNT_LOAD;
            acc     <= {{W{1'b0}}, (op_is_div(op) ? in_abs_1 : in_abs_2)};
            if (op_is_div(op) && (operand_2 == '0)) begin
              result <= {operand_1, {W{1'b1}}};
              done   <= 1'b1;
              state  <= ST_DONE;
            end else begin
              busy  <= 1'b1;
              state <= op_is_div(op) ? ST_DIV : ST_MUL;
            end
          end
        end

        ST_MUL: begin
          if (FAST_MUL != 0) begin
            acc   <= fast_prod;
            state <= ST_FIX;
          end else begin
            acc     <= mul_next;
            counter <= counter - CNT_LAST;
            if (counter == CNT_LAST) begin
              state <= ST_FIX;
            end
          end
        end

        ST_DIV: begin
          acc     <= div_next;
          counter <= counter - CNT_LAST;
          if (counter == CNT_LAST) begin
            state <= ST_FIX;
          end
        end

        ST_FIX: begin
          result <= is_div ? {fix_rem, fix_quot} : fix_prod;
          busy   <= 1'b0;
          done   <= 1'b1;
          state  <= ST_DONE;
        end

        ST_DONE: begin
          if (!hold) begin
            done  <= 1'b0;
            state <= ST_IDLE;
          end
        end

        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: drives an iterative-multiply and a
// fast-multiply instance in lockstep and compares both against an arithmetic
// reference model, covering latency, flush, reset and hold behaviour.
module tb_mult_div_unit;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        start;
  logic [1:0]  op;
  logic [31:0] operand_1;
  logic [31:0] operand_2;
  logic        hold;
  logic        busy_s;
  logic        done_s;
  logic [63:0] result_s;
  logic        busy_f;
  logic        done_f;
  logic [63:0] result_f;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [63:0] last_exp = '0;

  mult_div_unit #(.DATA_WIDTH(32), .FAST_MUL(0)) dut_s (
    .clk(clk), .rst(rst), .flush(flush), .start(start), .op(op),
    .operand_1(operand_1), .operand_2(operand_2), .hold(hold),
    .busy(busy_s), .done(done_s), .result(result_s)
  );

  mult_div_unit #(.DATA_WIDTH(32), .FAST_MUL(1)) dut_f (
    .clk(clk), .rst(rst), .flush(flush), .start(start), .op(op),
    .operand_1(operand_1), .operand_2(operand_2), .hold(hold),
    .busy(busy_f), .done(done_f), .result(result_f)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Architectural result computed with plain 64-bit arithmetic.
  function automatic logic [63:0] refModel(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, sq, sr;
    logic [63:0]        ua, ub, uq, ur;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (o)
      2'b00: return sa * sb;
      2'b01: return ua * ub;
      2'b10: begin
        if (b == 32'h0) return {a, 32'hFFFFFFFF};
        sq = sa / sb;
        sr = sa % sb;
        return {sr[31:0], sq[31:0]};
      end
      default: begin
        if (b == 32'h0) return {a, 32'hFFFFFFFF};
        uq = ua / ub;
        ur = ua % ub;
        return {ur[31:0], uq[31:0]};
      end
    endcase
  endfunction

  // Cycle (start cycle = 0) in which done is first seen.
  function automatic int expLat(input bit fast, input logic [1:0] o, input logic [31:0] b);
    if (o[1] && (b == 32'h0)) return 1;
    if (!o[1] && fast) return 3;
    return 34;
  endfunction

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFFFFFF;
      3: return 32'h80000000;
      default: return $urandom;
    endcase
  endfunction

  // Issues one operation (start also held, with scrambled operands, in the
  // following cycle where it must be ignored) and checks both instances.
  task automatic applyStimulus(input string tag, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] exp, cap_s, cap_f;
    int lat_s, lat_f, bc_s, bc_f, dc_s, dc_f;
    exp = refModel(o, a, b);
    lat_s = -1; lat_f = -1; bc_s = 0; bc_f = 0; dc_s = 0; dc_f = 0;
    cap_s = '0; cap_f = '0;
    @(posedge clk); #1;
    start = 1'b1; op = o; operand_1 = a; operand_2 = b;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin
        op = 2'($urandom_range(0, 3));
        operand_1 = $urandom;
        operand_2 = $urandom;
      end
      if (k == 2) start = 1'b0;
      if (busy_s) bc_s++;
      if (busy_f) bc_f++;
      if (done_s) begin
        dc_s++;
        if (lat_s < 0) begin lat_s = k; cap_s = result_s; end
      end
      if (done_f) begin
        dc_f++;
        if (lat_f < 0) begin lat_f = k; cap_f = result_f; end
      end
    end
    checkOutput({tag, " result_s"}, cap_s, exp);
    checkOutput({tag, " result_f"}, cap_f, exp);
    checkOutput({tag, " latency_s"}, 64'(lat_s), 64'(expLat(1'b0, o, b)));
    checkOutput({tag, " latency_f"}, 64'(lat_f), 64'(expLat(1'b1, o, b)));
    checkOutput({tag, " busy_cycles_s"}, 64'(bc_s), 64'(expLat(1'b0, o, b) - 1));
    checkOutput({tag, " busy_cycles_f"}, 64'(bc_f), 64'(expLat(1'b1, o, b) - 1));
    checkOutput({tag, " done_cycles_s"}, 64'(dc_s), 64'd1);
    checkOutput({tag, " done_cycles_f"}, 64'(dc_f), 64'd1);
    checkOutput({tag, " held_result_s"}, result_s, exp);
    checkOutput({tag, " held_result_f"}, result_f, exp);
    last_exp = exp;
  endtask

  initial begin
    logic [63:0] exp;
    int          lat, dcs, dcf, stable;
    bit          seen_done;
    rst = 1'b1; flush = 1'b0; start = 1'b0; hold = 1'b0;
    op = 2'b00; operand_1 = '0; operand_2 = '0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset busy_s", 64'(busy_s), 64'd0);
    checkOutput("reset done_s", 64'(done_s), 64'd0);
    checkOutput("reset result_s", result_s, 64'd0);
    checkOutput("reset busy_f", 64'(busy_f), 64'd0);
    checkOutput("reset done_f", 64'(done_f), 64'd0);
    checkOutput("reset result_f", result_f, 64'd0);
    rst = 1'b0;

    // Directed cases including sign, extreme-value and divide-by-zero.
    applyStimulus("mult_-3x7", 2'b00, 32'hFFFFFFFD, 32'd7);
    applyStimulus("multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
    applyStimulus("div_-7/2", 2'b10, 32'hFFFFFFF9, 32'd2);
    applyStimulus("divu_100/7", 2'b11, 32'd100, 32'd7);
    applyStimulus("divu_5/0", 2'b11, 32'd5, 32'd0);
    applyStimulus("div_min/-1", 2'b10, 32'h80000000, 32'hFFFFFFFF);
    applyStimulus("div_7/-2", 2'b10, 32'd7, 32'hFFFFFFFE);
    applyStimulus("mult_minxmin", 2'b00, 32'h80000000, 32'h80000000);
    applyStimulus("div_-9/0", 2'b10, 32'hFFFFFFF7, 32'd0);

    // Randomized operations.
    for (int i = 0; i < 24; i++) begin
      applyStimulus($sformatf("rand%0d", i), 2'($urandom_range(0, 3)), pickOperand(), pickOperand());
    end

    // Reset in the middle of a divide abandons it and clears the result.
    @(posedge clk); #1;
    start = 1'b1; op = 2'b10; operand_1 = 32'd1000; operand_2 = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("midreset busy_s", 64'(busy_s), 64'd0);
    checkOutput("midreset done_s", 64'(done_s), 64'd0);
    checkOutput("midreset result_s", result_s, 64'd0);
    checkOutput("midreset result_f", result_f, 64'd0);
    last_exp = '0;
    applyStimulus("after_reset", 2'b00, 32'd12345, 32'hFFFFFF00);

    // Flush in cycle 10 of a divide with start held throughout.
    seen_done = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; op = 2'b10; operand_1 = 32'hFFFF0000; operand_2 = 32'd9;
    for (int k = 1; k <= 11; k++) begin
      @(posedge clk); #1;
      if (done_s || done_f) seen_done = 1'b1;
      operand_1 = $urandom;
      operand_2 = $urandom;
      if (k == 9) checkOutput("flush busy_before", 64'(busy_s), 64'd1);
      if (k == 10) flush = 1'b1;
      if (k == 11) begin
        flush = 1'b0;
        start = 1'b0;
        checkOutput("flush busy_s", 64'(busy_s), 64'd0);
        checkOutput("flush busy_f", 64'(busy_f), 64'd0);
        checkOutput("flush done_s", 64'(done_s), 64'd0);
        checkOutput("flush result_s", result_s, last_exp);
        checkOutput("flush result_f", result_f, last_exp);
      end
    end
    checkOutput("flush no_done", 64'(seen_done), 64'd0);
    applyStimulus("after_flush", 2'b11, 32'd77777, 32'd123);

    // Completion held in DONE for 3 cycles; start during DONE is ignored.
    exp = refModel(2'b11, 32'hDEADBEEF, 32'd1234);
    hold = 1'b1;
    @(posedge clk); #1;
    start = 1'b1; op = 2'b11; operand_1 = 32'hDEADBEEF; operand_2 = 32'd1234;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    while (!done_s && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    checkOutput("hold latency", 64'(lat), 64'd34);
    dcs = 0; dcf = 0; stable = 1;
    for (int k = 0; k < 4; k++) begin
      if (done_s) dcs++;
      if (done_f) dcf++;
      if (result_s !== exp || result_f !== exp) stable = 0;
      if (k < 3) begin
        @(posedge clk); #1;
      end
      if (k == 0) begin
        start = 1'b1; op = 2'b00; operand_1 = 32'd3; operand_2 = 32'd5;
      end
      if (k == 1) start = 1'b0;
      if (k == 2) hold = 1'b0;
    end
    checkOutput("hold done_cycles_s", 64'(dcs), 64'd4);
    checkOutput("hold done_cycles_f", 64'(dcf), 64'd4);
    checkOutput("hold result_stable", 64'(stable), 64'd1);
    @(posedge clk); #1;
    checkOutput("hold idle_done", 64'(done_s), 64'd0);
    checkOutput("hold idle_busy", 64'(busy_s), 64'd0);
    @(posedge clk); #1;
    checkOutput("hold start_ignored", 64'(busy_s), 64'd0);
    checkOutput("hold result_kept", result_s, exp);
    last_exp = exp;
    applyStimulus("after_hold", 2'b00, 32'hFFFFFFFF, 32'h7FFFFFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
